dop_ramp_ctrl: RTL

DOP_RAMP_CTRL -- requirements
Module: dop_ramp_ctrl

---
 rtl/dop_ramp_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dop_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// dop_ramp_ctrl
// Ramps the period word of a doppler frequency stage from its current value
// toward a commanded target in fixed-size steps. Each update writes the new
// period to O_freq and then raises O_load for LOAD_HOLD cycles. Updates are
// separated by an O_load-low gap of R_intv cycles. The gap is the WAIT
// cycles plus the STEP cycle.
//
// Ports
//   I_clk       in   1   system clock, rising edge
//   I_reset     in   1   synchronous active-high reset
//   I_target    in  28   target period (0 = stop, static-high output)
//   I_step      in  16   period change per update (0 = jump to target)
//   I_interval  in  24   O_load-low cycles between updates (clamped)
//   I_start     in   1   latch target/step/interval and start or retarget
//   I_abort     in   1   stop ramping, hold current period
//   O_freq      out 32   period word, bits [31:28] always 0
//   O_load      out  1   load strobe, LOAD_HOLD cycles per update
//   O_busy      out  1   ramp in progress
//   O_done      out  1   one-cycle pulse when the target is reached
// -----------------------------------------------------------------------------
module dop_ramp_ctrl #(
  parameter int LOAD_HOLD    = 4,
  parameter int MIN_INTERVAL = 8
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic [27:0] I_target,
  input  logic [15:0] I_step,
  input  logic [23:0] I_interval,
  input  logic        I_start,
  input  logic        I_abort,
  output logic [31:0] O_freq,
  output logic        O_load,
  output logic        O_busy,
  output logic        O_done
);

  localparam int                HOLD_W    = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLD - 1);
  localparam logic [23:0]       MIN_INTV  = 24'(MIN_INTERVAL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP  = 3'd1,
    S_PULSE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Active ramp parameters and current period
  logic [27:0] cur_reg, tgt_reg;
  logic [15:0] step_reg;
  logic [23:0] intv_reg;

  // Start command captured during STEP/PULSE, applied when the pulse ends
  logic        start_pend_reg, abort_pend_reg;
  logic [27:0] p_tgt_reg;
  logic [15:0] p_step_reg;
  logic [23:0] p_intv_reg;

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [23:0]       intv_cnt_reg;

  logic load_reg, busy_reg, done_reg;
  logic load_next, busy_next, done_next;

  logic        hold_last, wait_last, start_any, abort_any, at_target, latch_en;
  logic [27:0] src_tgt;
  logic [15:0] src_step;
  logic [23:0] src_intv;
  logic [27:0] step_val;
  logic [28:0] sum_w;
  logic [27:0] diff_w, dec_w;

  assign hold_last = (state_reg == S_PULSE) && (hold_cnt_reg == '0);
  assign wait_last = (intv_cnt_reg <= 24'd1);
  assign start_any = start_pend_reg | I_start;
  assign abort_any = abort_pend_reg | I_abort;
  assign at_target = (cur_reg == tgt_reg);

  // A live start in the same cycle overrides an older pending one
  assign src_tgt  = I_start ? I_target   : p_tgt_reg;
  assign src_step = I_start ? I_step     : p_step_reg;
  assign src_intv = I_start ? I_interval : p_intv_reg;

  always_comb begin
    latch_en = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: latch_en = I_start;
      S_WAIT:         latch_en = I_start && !I_abort;
      S_PULSE:        latch_en = hold_last && !abort_any && start_any;
      default:        latch_en = 1'b0;
    endcase
  end

  // Step arithmetic. The upward sum is formed in 29 bits so a large step
  // near full scale clamps to the target instead of wrapping. Downward,
  // the distance to target is checked first so the subtraction never
  // crosses zero.
  always_comb begin
    sum_w    = {1'b0, cur_reg} + {13'd0, step_reg};
    diff_w   = cur_reg - tgt_reg;
    dec_w    = cur_reg - {12'd0, step_reg};
    step_val = cur_reg;
    if (step_reg == '0 || cur_reg == '0 || tgt_reg == '0) begin
      step_val = tgt_reg;
    end else if (cur_reg < tgt_reg) begin
      step_val = (sum_w >= {1'b0, tgt_reg}) ? tgt_reg : sum_w[27:0];
    end else if (cur_reg > tgt_reg) begin
      step_val = (diff_w <= {12'd0, step_reg}) ? tgt_reg : dec_w;
    end
  end

  // State and output registers
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_reg <= S_IDLE;
      load_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      load_reg  <= load_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: state_next = I_start ? S_STEP : S_IDLE;
      S_STEP:         state_next = S_PULSE;
      S_PULSE: begin
        if (hold_last) begin
          if (abort_any)      state_next = S_IDLE;
          else if (start_any) state_next = S_STEP;
          else if (at_target) state_next = S_DONE;
          else                state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_abort)        state_next = S_IDLE;
        else if (I_start)   state_next = S_STEP;
        else if (wait_last) state_next = S_STEP;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; registered above, so every output lags its state by one
  // cycle and O_freq (updated at the end of STEP) leads the load edge.
  always_comb begin
    busy_next = (state_reg == S_STEP) || (state_reg == S_PULSE) || (state_reg == S_WAIT);
    load_next = (state_reg == S_PULSE);
    done_next = (state_reg == S_DONE);
  end

  // Datapath: parameter latch, period update, counters, pending commands
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      cur_reg        <= '0;
      tgt_reg        <= '0;
      step_reg       <= '0;
      intv_reg       <= '0;
      p_tgt_reg      <= '0;
      p_step_reg     <= '0;
      p_intv_reg     <= '0;
      start_pend_reg <= 1'b0;
      abort_pend_reg <= 1'b0;
      hold_cnt_reg   <= '0;
      intv_cnt_reg   <= '0;
    end else begin
      if (latch_en) begin
        tgt_reg  <= src_tgt;
        step_reg <= src_step;
        intv_reg <= (src_intv < MIN_INTV) ? MIN_INTV : src_intv;
      end

      case (state_reg)
        S_STEP: begin
          cur_reg      <= step_val;
          hold_cnt_reg <= HOLD_LAST;
        end
        S_PULSE: begin
          if (!hold_last) begin
            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
          end else if (!abort_any && !start_any && !at_target) begin
            // WAIT lasts intv-1 cycles; the following STEP completes the gap
            intv_cnt_reg <= (intv_reg == '0) ? '0 : intv_reg - 24'd1;
          end
        end
        S_WAIT: begin
          intv_cnt_reg <= intv_cnt_reg - 24'd1;
        end
        default: ;
      endcase

      // Commands arriving mid-update are held until the pulse finishes.
      // The last PULSE cycle sees live commands directly via *_any.
      if (state_reg == S_STEP || (state_reg == S_PULSE && !hold_last)) begin
        if (I_start) begin
          start_pend_reg <= 1'b1;
          p_tgt_reg      <= I_target;
          p_step_reg     <= I_step;
          p_intv_reg     <= I_interval;
        end
        if (I_abort) begin
          abort_pend_reg <= 1'b1;
        end
      end else begin
        start_pend_reg <= 1'b0;
        abort_pend_reg <= 1'b0;
      end
    end
  end

  assign O_freq = {4'b0000, cur_reg};
  assign O_load = load_reg;
  assign O_busy = busy_reg;
  assign O_done = done_reg;

endmodule
